// File: rtl/fp_mc_sequencer.sv
// Sequencer for the shared multi-cycle FP unit (FDIV.S / FSQRT.S): issues one op,
// counts its fixed latency, holds the result until the write port is granted.
module fp_mc_sequencer #(
  parameter int unsigned LAT_DIV  = 12,
  parameter int unsigned LAT_SQRT = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       IssueE,
  input  logic       OpE,
  input  logic [4:0] RdE,
  input  logic       IsMcD,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] RdD,
  input  logic       KillMc,
  input  logic       WbGrant,
  output logic       UnitStart,
  output logic       UnitOp,
  output logic       UnitAbort,
  output logic       BusyStallD,
  output logic       WbReq,
  output logic [4:0] WbRd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LOAD_DIV  = CNT_W'(LAT_DIV - 2);
  localparam logic [CNT_W-1:0] LOAD_SQRT = CNT_W'(LAT_SQRT - 2);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [4:0]       pend_rd, pend_rd_nx;
  logic             pend_op, pend_op_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_rd <= '0;
      pend_op <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pend_rd <= pend_rd_nx;
      pend_op <= pend_op_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pend_rd_nx = pend_rd;
    pend_op_nx = pend_op;
    UnitStart  = 1'b0;
    UnitOp     = pend_op;
    UnitAbort  = 1'b0;

    case (state)
      IDLE: begin
        // The start pulse is combinational from IssueE, so it is gated by reset too.
        if (IssueE && !KillMc && rst_n) begin
          UnitStart  = 1'b1;
          UnitOp     = OpE;
          pend_rd_nx = RdE;
          pend_op_nx = OpE;
          cnt_nx     = OpE ? LOAD_SQRT : LOAD_DIV;
          state_nx   = BUSY;
        end
      end
      BUSY: begin
        if (KillMc) begin
          UnitAbort  = 1'b1;
          state_nx   = IDLE;
          cnt_nx     = '0;
          pend_rd_nx = '0;
          pend_op_nx = 1'b0;
        end else if (cnt == '0) begin
          state_nx = DONE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      DONE: begin
        // Abort outranks the write-port grant.
        if (KillMc) begin
          UnitAbort  = 1'b1;
          state_nx   = IDLE;
          cnt_nx     = '0;
          pend_rd_nx = '0;
          pend_op_nx = 1'b0;
        end else if (WbGrant) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign WbReq = (state == DONE);
  assign WbRd  = WbReq ? pend_rd : '0;

  // f0 is a real register, so rd==0 is not excluded from the dependency match.
  assign BusyStallD = (state != IDLE) &&
                      (IsMcD || (Rs1D == pend_rd) || (Rs2D == pend_rd) || (RdD == pend_rd));

endmodule

// File: tb/tb_fp_mc_sequencer.sv
// Scoreboard bench for fp_mc_sequencer: stimulus pushes expected start/abort/write-back
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_fp_mc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       IssueE, OpE, IsMcD, KillMc, WbGrant;
  logic [4:0] RdE, Rs1D, Rs2D, RdD;
  logic       UnitStart, UnitOp, UnitAbort, BusyStallD, WbReq;
  logic [4:0] WbRd;

  fp_mc_sequencer #(.LAT_DIV(12), .LAT_SQRT(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .IssueE(IssueE), .OpE(OpE), .RdE(RdE),
    .IsMcD(IsMcD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .KillMc(KillMc),
    .WbGrant(WbGrant), .UnitStart(UnitStart), .UnitOp(UnitOp),
    .UnitAbort(UnitAbort), .BusyStallD(BusyStallD), .WbReq(WbReq), .WbRd(WbRd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_START = 0;
  localparam int K_ABORT = 1;
  localparam int K_WB    = 2;

  typedef struct {
    int         kind;
    logic       op;
    logic [4:0] rd;
    int         c1;
    int         c2;
  } ev_t;

  ev_t q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic report(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    report(name, got == exp, $sformatf("got=%0d expected=%0d at cycle %0d", got, exp, cyc));
  endtask

  task automatic push(input int kind, input logic op, input logic [4:0] rd,
                      input int c1, input int c2);
    ev_t e;
    e.kind = kind; e.op = op; e.rd = rd; e.c1 = c1; e.c2 = c2;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic clear_d();
    IsMcD = 1'b0; Rs1D = 5'd20; Rs2D = 5'd21; RdD = 5'd22;
  endtask

  // Monitor
  logic       wb_prev = 1'b0;
  int         wb_rise = 0;
  logic [4:0] wb_rd0 = '0;
  always @(negedge clk) begin
    ev_t e;
    if (!rst_n) begin
      wb_prev = 1'b0;
    end else begin
      if (UnitStart) begin
        if (q.size() == 0 || q[0].kind != K_START) begin
          report("start_event", 1'b0, $sformatf("got unexpected start at cycle %0d, expected none", cyc));
        end else begin
          e = q.pop_front();
          report("start_event", (UnitOp == e.op) && (cyc == e.c1),
                 $sformatf("got op=%0d cycle=%0d expected op=%0d cycle=%0d", UnitOp, cyc, e.op, e.c1));
        end
      end
      if (UnitAbort) begin
        if (q.size() == 0 || q[0].kind != K_ABORT) begin
          report("abort_event", 1'b0, $sformatf("got unexpected abort at cycle %0d, expected none", cyc));
        end else begin
          e = q.pop_front();
          report("abort_event", cyc == e.c1,
                 $sformatf("got cycle=%0d expected cycle=%0d", cyc, e.c1));
        end
      end
      if (WbReq && !wb_prev) begin
        wb_rise = cyc;
        wb_rd0  = WbRd;
      end else if (WbReq) begin
        report("wbrd_stable", WbRd == wb_rd0,
               $sformatf("got WbRd=%0d expected %0d at cycle %0d", WbRd, wb_rd0, cyc));
      end
      if (WbReq && WbGrant && !UnitAbort) begin
        if (q.size() == 0 || q[0].kind != K_WB) begin
          report("wb_event", 1'b0, $sformatf("got unexpected write-back rd=%0d at cycle %0d, expected none", WbRd, cyc));
        end else begin
          e = q.pop_front();
          report("wb_event", (WbRd == e.rd) && (wb_rise == e.c1) && (cyc == e.c2),
                 $sformatf("got rd=%0d rise=%0d grant=%0d expected rd=%0d rise=%0d grant=%0d",
                           WbRd, wb_rise, cyc, e.rd, e.c1, e.c2));
        end
      end
      wb_prev = WbReq;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst_n = 1'b0; IssueE = 1'b0; OpE = 1'b0; RdE = '0; KillMc = 1'b0; WbGrant = 1'b0;
    clear_d();
    IsMcD = 1'b1;
    #1;
    chk("reset_start", UnitStart, 0);
    chk("reset_abort", UnitAbort, 0);
    chk("reset_stall", BusyStallD, 0);
    chk("reset_wbreq", WbReq, 0);
    chk("reset_wbrd", WbRd, 0);
    IsMcD = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    // FDIV rd5, grant held high throughout (ignored until DONE)
    t = cyc;
    IssueE = 1'b1; OpE = 1'b0; RdE = 5'd5; WbGrant = 1'b1;
    push(K_START, 1'b0, 5'd0, t, 0);
    push(K_WB, 1'b0, 5'd5, t + 12, t + 12);
    step();
    IssueE = 1'b0; IsMcD = 1'b1;
    @(negedge clk);
    chk("s1_busy_stall", BusyStallD, 1);
    step();
    IsMcD = 1'b0;
    IssueE = 1'b1; OpE = 1'b1; RdE = 5'd9;   // illegal issue while busy: must be ignored
    step();
    IssueE = 1'b0;
    wait_until(t + 13);
    IsMcD = 1'b1; WbGrant = 1'b0;
    @(negedge clk);
    chk("s1_idle_stall", BusyStallD, 0);
    chk("s1_idle_wbreq", WbReq, 0);
    clear_d();

    // FSQRT rd7, grant withheld until T+20
    step();
    t = cyc;
    IssueE = 1'b1; OpE = 1'b1; RdE = 5'd7;
    push(K_START, 1'b1, 5'd0, t, 0);
    push(K_WB, 1'b1, 5'd7, t + 16, t + 20);
    step();
    IssueE = 1'b0;
    wait_until(t + 16);
    @(negedge clk);
    chk("s2_wbreq_t16", WbReq, 1);
    chk("s2_wbrd_t16", WbRd, 7);
    wait_until(t + 20);
    WbGrant = 1'b1;
    step();
    WbGrant = 1'b0; IsMcD = 1'b1;
    @(negedge clk);
    chk("s2_idle_stall", BusyStallD, 0);
    chk("s2_idle_wbreq", WbReq, 0);
    clear_d();

    // FDIV rd3: dependency stalls, then kill while busy
    step();
    t = cyc;
    IssueE = 1'b1; OpE = 1'b0; RdE = 5'd3;
    push(K_START, 1'b0, 5'd0, t, 0);
    step();
    IssueE = 1'b0; Rs1D = 5'd3;
    @(negedge clk); chk("s3_rs1_stall", BusyStallD, 1);
    step();
    Rs1D = 5'd20; Rs2D = 5'd3;
    @(negedge clk); chk("s3_rs2_stall", BusyStallD, 1);
    step();
    Rs2D = 5'd21; RdD = 5'd3;
    @(negedge clk); chk("s3_rd_stall", BusyStallD, 1);
    step();
    RdD = 5'd22; IsMcD = 1'b1;
    @(negedge clk); chk("s3_mc_stall", BusyStallD, 1);
    step();
    IsMcD = 1'b0;
    @(negedge clk); chk("s3_unrelated", BusyStallD, 0);
    step();
    KillMc = 1'b1;
    push(K_ABORT, 1'b0, 5'd0, t + 6, 0);
    step();
    KillMc = 1'b0; IsMcD = 1'b1;
    @(negedge clk);
    chk("s3_kill_stall", BusyStallD, 0);
    chk("s3_kill_wbreq", WbReq, 0);
    clear_d();

    // FDIV rd0: f0 dependency, kill at T+5, then kill blocks an issue in IDLE
    step();
    t = cyc;
    IssueE = 1'b1; OpE = 1'b0; RdE = 5'd0;
    push(K_START, 1'b0, 5'd0, t, 0);
    step();
    IssueE = 1'b0; Rs1D = 5'd0; Rs2D = 5'd1; RdD = 5'd2;
    @(negedge clk); chk("s4_f0_stall", BusyStallD, 1);
    clear_d();
    wait_until(t + 5);
    KillMc = 1'b1;
    push(K_ABORT, 1'b0, 5'd0, t + 5, 0);
    @(negedge clk); chk("s4_abort_t5", UnitAbort, 1);
    step();
    KillMc = 1'b0; IsMcD = 1'b1;
    @(negedge clk);
    chk("s4_kill_stall", BusyStallD, 0);
    chk("s4_kill_wbreq", WbReq, 0);
    step();
    IsMcD = 1'b0; IssueE = 1'b1; KillMc = 1'b1; RdE = 5'd6;
    @(negedge clk);
    chk("s4_killidle_start", UnitStart, 0);
    chk("s4_killidle_abort", UnitAbort, 0);
    step();
    IssueE = 1'b0; KillMc = 1'b0; IsMcD = 1'b1;
    @(negedge clk); chk("s4_still_idle", BusyStallD, 0);
    clear_d();
    wait_until(t + 14);
    @(negedge clk); chk("s4_no_wbreq", WbReq, 0);

    // FDIV rd4: kill and grant together in DONE, abort wins
    step();
    t = cyc;
    IssueE = 1'b1; OpE = 1'b0; RdE = 5'd4;
    push(K_START, 1'b0, 5'd0, t, 0);
    push(K_ABORT, 1'b0, 5'd0, t + 12, 0);
    step();
    IssueE = 1'b0;
    wait_until(t + 12);
    KillMc = 1'b1; WbGrant = 1'b1;
    @(negedge clk);
    chk("s5_done_wbreq", WbReq, 1);
    chk("s5_done_wbrd", WbRd, 4);
    step();
    KillMc = 1'b0; WbGrant = 1'b0; IsMcD = 1'b1;
    @(negedge clk);
    chk("s5_after_stall", BusyStallD, 0);
    chk("s5_after_wbreq", WbReq, 0);
    clear_d();

    // FSQRT rd9, asynchronous reset mid-BUSY
    step();
    t = cyc;
    IssueE = 1'b1; OpE = 1'b1; RdE = 5'd9;
    push(K_START, 1'b1, 5'd0, t, 0);
    step();
    IssueE = 1'b0;
    wait_until(t + 6);
    IsMcD = 1'b1; Rs1D = 5'd9;
    #1;
    chk("s6_pre_stall", BusyStallD, 1);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_start", UnitStart, 0);
    chk("s6_rst_abort", UnitAbort, 0);
    chk("s6_rst_stall", BusyStallD, 0);
    chk("s6_rst_wbreq", WbReq, 0);
    chk("s6_rst_wbrd", WbRd, 0);
    step(); step();
    rst_n = 1'b1;
    clear_d();
    step();

    // Post-reset issue behaves as the first scenario
    t = cyc;
    IssueE = 1'b1; OpE = 1'b0; RdE = 5'd5; WbGrant = 1'b1;
    push(K_START, 1'b0, 5'd0, t, 0);
    push(K_WB, 1'b0, 5'd5, t + 12, t + 12);
    step();
    IssueE = 1'b0;
    wait_until(t + 13);
    IsMcD = 1'b1; WbGrant = 1'b0;
    @(negedge clk);
    chk("s7_idle_stall", BusyStallD, 0);
    clear_d();
    step(); step();
    @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
